// File: rtl/core_result_collector.sv
// core_result_collector: captures 4-word MD5 digests into per-(core, ctx) slots and serializes
// them round-robin over a valid/ready output. Define COLLECTOR_COUNT_EN to build results_total.
module core_result_collector #(
    parameter int N_CORES     = 3,
    parameter int N_CORES_MSB = (N_CORES > 1) ? $clog2(N_CORES) - 1 : 0,
    parameter int WORDS       = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [N_CORES-1:0]    core_out_en,
    input  logic [N_CORES-1:0]    core_out_ctx,
    input  logic [N_CORES-1:0]    core_out_seq,
    input  logic [32*N_CORES-1:0] core_dout,
    output logic [31:0]           dout,
    output logic                  dout_valid,
    input  logic                  rd_en,
    output logic [N_CORES_MSB:0]  dout_core,
    output logic                  dout_ctx,
    output logic                  dout_seq,
    output logic                  dout_last,
    output logic                  err_overflow,
    output logic                  err_protocol,
    output logic [15:0]           results_total
);

    localparam int N_SLOTS = 2 * N_CORES;
    localparam int SW      = $clog2(N_SLOTS);
    localparam int WW      = $clog2(WORDS);
    localparam int CW      = N_CORES_MSB + 1;
    localparam logic [WW-1:0] LAST_W = WW'(WORDS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    function automatic logic [SW-1:0] slot_of(input int core, input logic ctx);
        return SW'(2 * core) | SW'(ctx);
    endfunction

    // Slot storage
    logic [31:0]        data_q [N_SLOTS][WORDS];
    logic [N_SLOTS-1:0] seq_q;
    logic [N_SLOTS-1:0] full_q, full_d;
    logic [N_SLOTS-1:0] free_now;

    // Per-core capture state
    logic [WW-1:0]      cap_cnt_q [N_CORES];
    logic [N_CORES-1:0] cap_busy_q;
    logic [N_CORES-1:0] cap_drop_q;
    logic [N_CORES-1:0] cap_ctx_q;

    logic [N_CORES-1:0] start, start_drop, wr_en, done;
    logic [SW-1:0]      wr_slot [N_CORES];
    logic [WW-1:0]      wr_word [N_CORES];

    // Readout state
    state_e             state_q;
    logic [SW-1:0]      sel_q;
    logic [SW-1:0]      ptr_q;
    logic [WW-1:0]      widx_q;

    logic [N_SLOTS-1:0] avail;
    logic               pick_found;
    logic [SW-1:0]      pick_slot;
    logic [SW-1:0]      pick_next;

    // A slot being freed this cycle accepts a new digest instead of overflowing.
    always_comb begin
        free_now = '0;
        if (state_q == StSend && rd_en && widx_q == LAST_W) begin
            free_now[sel_q] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            start[i]      = core_out_en[i] && !cap_busy_q[i];
            start_drop[i] = full_q[slot_of(i, core_out_ctx[i])] &&
                            !free_now[slot_of(i, core_out_ctx[i])];
            wr_slot[i]    = cap_busy_q[i] ? slot_of(i, cap_ctx_q[i]) : slot_of(i, core_out_ctx[i]);
            wr_word[i]    = cap_busy_q[i] ? cap_cnt_q[i] : '0;
            wr_en[i]      = start[i] ? !start_drop[i] : (cap_busy_q[i] && !cap_drop_q[i]);
            done[i]       = cap_busy_q[i] && !cap_drop_q[i] && (cap_cnt_q[i] == LAST_W);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CORES; i++) begin
                cap_cnt_q[i] <= '0;
            end
            cap_busy_q   <= '0;
            cap_drop_q   <= '0;
            cap_ctx_q    <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (start[i]) begin
                    cap_busy_q[i] <= 1'b1;
                    cap_cnt_q[i]  <= WW'(1);
                    cap_ctx_q[i]  <= core_out_ctx[i];
                    cap_drop_q[i] <= start_drop[i];
                    if (start_drop[i]) begin
                        err_overflow <= 1'b1;
                    end
                end else if (cap_busy_q[i]) begin
                    if (core_out_en[i]) begin
                        err_protocol <= 1'b1;
                    end
                    cap_cnt_q[i] <= cap_cnt_q[i] + WW'(1);
                    if (cap_cnt_q[i] == LAST_W) begin
                        cap_busy_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Payload needs no reset: a slot is only read while marked full.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (wr_en[i]) begin
                data_q[wr_slot[i]][wr_word[i]] <= core_dout[32*i +: 32];
                if (!cap_busy_q[i]) begin
                    seq_q[wr_slot[i]] <= core_out_seq[i];
                end
            end
        end
    end

    always_comb begin
        full_d = full_q & ~free_now;
        for (int i = 0; i < N_CORES; i++) begin
            if (done[i]) begin
                full_d[wr_slot[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Round-robin search starting at ptr_q; the slot being served is never re-picked.
    always_comb begin
        int idx;
        idx        = 0;
        avail      = full_q;
        if (state_q == StSend) begin
            avail[sel_q] = 1'b0;
        end
        pick_found = 1'b0;
        pick_slot  = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N_SLOTS;
            if (avail[idx]) begin
                pick_found = 1'b1;
                pick_slot  = SW'(idx);
            end
        end
        pick_next = (pick_slot == SW'(N_SLOTS - 1)) ? '0 : pick_slot + SW'(1);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            ptr_q      <= '0;
            widx_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_core  <= '0;
            dout_ctx   <= 1'b0;
            dout_seq   <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q    <= StSend;
                        sel_q      <= pick_slot;
                        ptr_q      <= pick_next;
                        widx_q     <= '0;
                        dout       <= data_q[pick_slot][0];
                        dout_valid <= 1'b1;
                        dout_core  <= CW'(pick_slot >> 1);
                        dout_ctx   <= pick_slot[0];
                        dout_seq   <= seq_q[pick_slot];
                        dout_last  <= 1'b0;
                    end
                end
                StSend: begin
                    if (rd_en) begin
                        if (widx_q == LAST_W) begin
                            if (pick_found) begin
                                sel_q      <= pick_slot;
                                ptr_q      <= pick_next;
                                widx_q     <= '0;
                                dout       <= data_q[pick_slot][0];
                                dout_core  <= CW'(pick_slot >> 1);
                                dout_ctx   <= pick_slot[0];
                                dout_seq   <= seq_q[pick_slot];
                                dout_last  <= 1'b0;
                            end else begin
                                state_q    <= StIdle;
                                dout_valid <= 1'b0;
                                dout_last  <= 1'b0;
                            end
                        end else begin
                            widx_q    <= widx_q + WW'(1);
                            dout      <= data_q[sel_q][widx_q + WW'(1)];
                            dout_last <= ((widx_q + WW'(1)) == LAST_W);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef COLLECTOR_COUNT_EN
    logic [15:0] total_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            total_q <= '0;
        end else if (|free_now) begin
            total_q <= total_q + 16'd1;
        end
    end

    assign results_total = total_q;
`else
    assign results_total = 16'd0;
`endif

endmodule

// File: tb/tb_core_result_collector.sv
// Self-checking bench for core_result_collector: directed scenarios plus random traffic,
// compared every cycle against a slot-level behavioural model.
module tb_core_result_collector;

`ifdef COLLECTOR_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic        CLK;
    logic        rst;
    logic [2:0]  core_out_en, core_out_ctx, core_out_seq;
    logic [95:0] core_dout;
    logic [31:0] dout;
    logic        dout_valid, rd_en;
    logic [1:0]  dout_core;
    logic        dout_ctx, dout_seq, dout_last, err_overflow, err_protocol;
    logic [15:0] results_total;

    core_result_collector dut (
        .CLK          (CLK),
        .rst          (rst),
        .core_out_en  (core_out_en),
        .core_out_ctx (core_out_ctx),
        .core_out_seq (core_out_seq),
        .core_dout    (core_dout),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .rd_en        (rd_en),
        .dout_core    (dout_core),
        .dout_ctx     (dout_ctx),
        .dout_seq     (dout_seq),
        .dout_last    (dout_last),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol),
        .results_total(results_total)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Inputs for the next cycle
    logic        nx_rst, nx_rd;
    logic [2:0]  nx_en, nx_ctx, nx_seq;
    logic [95:0] nx_dout;

    // Model: slot contents, in-flight digests per core, and the reader position
    bit          m_full [6];
    logic [31:0] m_data [6][4];
    bit          m_seq  [6];
    bit          c_busy [3];
    int          c_n    [3];
    bit          c_ctx  [3];
    bit          c_seqv [3];
    bit          c_drop [3];
    logic [31:0] c_w    [3][4];
    bit          m_valid, m_ov, m_pr;
    int          m_slot, m_widx, m_ptr, m_total;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 6; s++) m_full[s] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_busy[i] = 1'b0;
            c_n[i]    = 0;
        end
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_pr    = 1'b0;
        m_slot  = 0;
        m_widx  = 0;
        m_ptr   = 0;
        m_total = 0;
    endtask

    task automatic model_step();
        bit full_old [6];
        bit set_full [6];
        bit freeing;
        int freed, s, excl, found;
        if (nx_rst) begin
            model_reset();
            return;
        end
        full_old = m_full;
        for (int k = 0; k < 6; k++) set_full[k] = 1'b0;
        freeing = m_valid && nx_rd && (m_widx == 3);
        freed   = m_slot;
        for (int i = 0; i < 3; i++) begin
            if (nx_en[i] && !c_busy[i]) begin
                s         = 2 * i + int'(nx_ctx[i]);
                c_drop[i] = full_old[s] && !(freeing && s == freed);
                if (c_drop[i]) m_ov = 1'b1;
                c_busy[i]  = 1'b1;
                c_n[i]     = 1;
                c_ctx[i]   = nx_ctx[i];
                c_seqv[i]  = nx_seq[i];
                c_w[i][0]  = nx_dout[32*i +: 32];
            end else if (c_busy[i]) begin
                if (nx_en[i]) m_pr = 1'b1;
                c_w[i][c_n[i]] = nx_dout[32*i +: 32];
                c_n[i]++;
                if (c_n[i] == 4) begin
                    c_busy[i] = 1'b0;
                    if (!c_drop[i]) begin
                        s = 2 * i + int'(c_ctx[i]);
                        for (int w = 0; w < 4; w++) m_data[s][w] = c_w[i][w];
                        m_seq[s]    = c_seqv[i];
                        set_full[s] = 1'b1;
                    end
                end
            end
        end
        excl = -1;
        if (m_valid && nx_rd && m_widx < 3) begin
            m_widx++;
        end else if (!m_valid || nx_rd) begin
            if (m_valid) begin
                m_total++;
                excl = m_slot;
            end
            found = -1;
            for (int k = 0; k < 6; k++) begin
                s = (m_ptr + k) % 6;
                if (found < 0 && full_old[s] && s != excl) found = s;
            end
            if (found >= 0) begin
                m_valid = 1'b1;
                m_slot  = found;
                m_widx  = 0;
                m_ptr   = (found + 1) % 6;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (freeing) m_full[freed] = 1'b0;
        for (int k = 0; k < 6; k++) if (set_full[k]) m_full[k] = 1'b1;
    endtask

    task automatic compare();
        chk("dout_valid", dout_valid, m_valid);
        chk("dout_last", dout_last, m_valid && m_widx == 3);
        if (m_valid) begin
            chk("dout", dout, m_data[m_slot][m_widx]);
            chk("dout_core", dout_core, m_slot / 2);
            chk("dout_ctx", dout_ctx, m_slot % 2);
            chk("dout_seq", dout_seq, m_seq[m_slot]);
        end
        chk("err_overflow", err_overflow, m_ov);
        chk("err_protocol", err_protocol, m_pr);
        chk("results_total", results_total, CountEn ? (m_total & 32'hFFFF) : 0);
    endtask

    task automatic step();
        @(negedge CLK);
        compare();
        rst          = nx_rst;
        rd_en        = nx_rd;
        core_out_en  = nx_en;
        core_out_ctx = nx_ctx;
        core_out_seq = nx_seq;
        core_dout    = nx_dout;
        model_step();
    endtask

    task automatic idle_inputs();
        nx_en   = '0;
        nx_ctx  = '0;
        nx_seq  = '0;
        nx_dout = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nx_rst = 1'b1;
        step();
        step();
        chk("rst dout_valid", dout_valid, 0);
        chk("rst dout", dout, 0);
        chk("rst tags", {dout_core, dout_ctx, dout_seq, dout_last}, 0);
        chk("rst errors", {err_overflow, err_protocol}, 0);
        chk("rst results_total", results_total, 0);
        nx_rst = 1'b0;
        step();
    endtask

    // Core i sends word base + i*256 + w; stray adds a second pulse on word 2.
    task automatic emit(input logic [2:0] mask, input logic [2:0] ctx, input logic [2:0] seq,
                        input logic [31:0] base, input logic [2:0] stray);
        for (int w = 0; w < 4; w++) begin
            nx_en  = (w == 0) ? mask : ((w == 2) ? stray : 3'b000);
            nx_ctx = ctx;
            nx_seq = seq;
            for (int i = 0; i < 3; i++) nx_dout[32*i +: 32] = base + 32'(i << 8) + 32'(w);
            step();
        end
        idle_inputs();
    endtask

    int drv_left [3];

    initial begin
        rst = 1'b1;
        rd_en = 1'b0;
        core_out_en = '0;
        core_out_ctx = '0;
        core_out_seq = '0;
        core_dout = '0;
        nx_rd = 1'b0;
        model_reset();
        do_reset();

        // Single digest, core 1 ctx 0 seq 1
        nx_rd = 1'b1;
        emit(3'b010, 3'b000, 3'b010, 32'hA000_0000, 3'b000);
        step();
        for (int w = 0; w < 4; w++) begin
            step();
            chk("t1 dout", dout, 32'hA000_0100 + 32'(w));
            chk("t1 valid", dout_valid, 1);
            chk("t1 core/seq", {dout_core, dout_seq}, 3'b011);
            chk("t1 last", dout_last, w == 3);
        end
        step();
        chk("t1 idle", dout_valid, 0);
        chk("t1 total", results_total, CountEn ? 1 : 0);

        // Cores 0 and 2 together: back-to-back, core 0 first
        do_reset();
        nx_rd = 1'b1;
        emit(3'b101, 3'b000, 3'b000, 32'hB000_0000, 3'b000);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2 valid", dout_valid, 1);
            chk("t2 core", dout_core, (k < 4) ? 0 : 2);
            chk("t2 dout", dout, 32'hB000_0000 + ((k < 4) ? 0 : 32'h200) + 32'(k % 4));
        end
        step();
        chk("t2 idle", dout_valid, 0);

        // Overflow: core 0 ctx 1 twice while stalled
        do_reset();
        nx_rd = 1'b0;
        emit(3'b001, 3'b001, 3'b001, 32'hC000_0000, 3'b000);
        emit(3'b001, 3'b001, 3'b000, 32'hD000_0000, 3'b000);
        chk("t3 overflow", err_overflow, 1);
        chk("t3 stalled word", dout, 32'hC000_0000);
        nx_rd = 1'b1;
        for (int w = 0; w < 4; w++) begin
            step();
            chk("t3 dout", dout, 32'hC000_0000 + 32'(w));
            chk("t3 ctx/seq", {dout_ctx, dout_seq}, 2'b11);
        end
        step();
        chk("t3 dropped", dout_valid, 0);

        // Protocol: stray pulse on word 2
        do_reset();
        nx_rd = 1'b1;
        emit(3'b001, 3'b000, 3'b000, 32'hE000_0000, 3'b001);
        chk("t4 protocol", err_protocol, 1);
        step();
        for (int w = 0; w < 4; w++) begin
            step();
            chk("t4 dout", dout, 32'hE000_0000 + 32'(w));
        end
        step();
        chk("t4 single digest", dout_valid, 0);

        // Free and new capture on slot {0,0} in the same cycle
        do_reset();
        nx_rd = 1'b1;
        emit(3'b001, 3'b000, 3'b000, 32'h1000_0000, 3'b000);
        repeat (4) step();
        chk("t5 align", dout, 32'h1000_0002);
        emit(3'b001, 3'b000, 3'b001, 32'h2000_0000, 3'b000);
        chk("t5 no overflow", err_overflow, 0);
        step();
        step();
        chk("t5 new digest", dout, 32'h2000_0000);
        chk("t5 new seq", {dout_valid, dout_seq}, 2'b11);
        repeat (4) step();

        // Asynchronous reset in the middle of SEND
        do_reset();
        nx_rd = 1'b1;
        emit(3'b010, 3'b001, 3'b000, 32'h3000_0000, 3'b000);
        repeat (3) step();
        chk("t6 mid send", dout, 32'h3000_0101);
        rst = 1'b1;
        #1;
        chk("t6 async clear", dout_valid, 0);
        model_reset();
        nx_rst = 1'b1;
        step();
        nx_rst = 1'b0;
        step();
        repeat (10) step();
        chk("t6 no stale", dout_valid, 0);

        // Random traffic
        for (int i = 0; i < 3; i++) drv_left[i] = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            nx_rst = ($urandom_range(0, 999) == 0);
            nx_rd  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                nx_dout[32*i +: 32] = $urandom;
                nx_ctx[i] = 1'($urandom_range(0, 1));
                nx_seq[i] = 1'($urandom_range(0, 1));
                if (nx_rst) begin
                    nx_en[i]    = 1'b0;
                    drv_left[i] = 0;
                end else if (drv_left[i] > 0) begin
                    drv_left[i]--;
                    nx_en[i] = ($urandom_range(0, 40) == 0);
                end else begin
                    nx_en[i] = ($urandom_range(0, 3) == 0);
                    if (nx_en[i]) drv_left[i] = 3;
                end
            end
            step();
        end
        nx_rst = 1'b0;
        idle_inputs();
        nx_rd = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
